// File: rtl/masked_aes_pkg.sv
// Shared types and mask helpers for the masked AES round datapath.
// The (m1, m2) mask pair expands to an 8-bit pattern applied to each byte.
package masked_aes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REFRESH = 2'd1,
        ST_SUB     = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    localparam logic [7:0] P_M1 = 8'h5E;
    localparam logic [7:0] P_M2 = 8'hA7;
    localparam logic [7:0] P_M3 = 8'hF9;

    function automatic logic [7:0] mask_pattern(input logic a, input logic b);
        logic [7:0] p;
        unique case ({a, b})
            2'b10:   p = P_M1;
            2'b01:   p = P_M2;
            2'b11:   p = P_M3;
            default: p = 8'h00;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Two-bit masked AES S-box: input and output share the same mask pattern.
// Purely combinational; the S-box itself is GF(2^8) inversion plus affine map.
module aes_sbox
    import masked_aes_pkg::*;
(
    input  logic i_0,
    input  logic i_1,
    input  logic i_2,
    input  logic i_3,
    input  logic i_4,
    input  logic i_5,
    input  logic i_6,
    input  logic i_7,
    input  logic MASK1,
    input  logic MASK2,
    output logic o_0,
    output logic o_1,
    output logic o_2,
    output logic o_3,
    output logic o_4,
    output logic o_5,
    output logic o_6,
    output logic o_7
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse, with 0 mapping to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int k = 1; k < 8; k++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] v;
        v = gf_inv(a);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]}
                 ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    logic [7:0] in_byte;
    logic [7:0] msk;
    logic [7:0] res;

    assign in_byte = {i_7, i_6, i_5, i_4, i_3, i_2, i_1, i_0};
    assign msk     = mask_pattern(MASK1, MASK2);
    assign res     = sbox(in_byte ^ msk) ^ msk;

    assign {o_7, o_6, o_5, o_4, o_3, o_2, o_1, o_0} = res;

endmodule

// File: rtl/masked_subbytes_ctrl.sv
// Byte-serial masked SubBytes sequencer with optional mask refresh.
// Holds the round state in place and hands the result out via valid/ready.
module masked_subbytes_ctrl
    import masked_aes_pkg::*;
#(
    parameter int NBYTES     = 16,
    parameter bit REFRESH_EN = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [8*NBYTES-1:0] in_state,
    input  logic                in_m1,
    input  logic                in_m2,
    input  logic [1:0]          rnd,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [8*NBYTES-1:0] out_state,
    output logic                out_m1,
    output logic                out_m2,
    output logic                busy
);

    localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int SW = 8 * NBYTES;
    localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [SW-1:0]  data_q, data_d;
    logic           m1_q, m1_d;
    logic           m2_q, m2_d;
    logic [1:0]     rnd_q, rnd_d;

    logic [7:0]     sel_byte;
    logic [7:0]     sub_byte;
    logic [7:0]     refresh_pat;

    assign sel_byte    = data_q[{cnt_q, 3'b000} +: 8];
    // Remask by the mask difference so the unmasked byte never appears
    assign refresh_pat = mask_pattern(m1_q ^ rnd_q[0], m2_q ^ rnd_q[1]);

    aes_sbox u_sbox (
        .i_0   (sel_byte[0]),
        .i_1   (sel_byte[1]),
        .i_2   (sel_byte[2]),
        .i_3   (sel_byte[3]),
        .i_4   (sel_byte[4]),
        .i_5   (sel_byte[5]),
        .i_6   (sel_byte[6]),
        .i_7   (sel_byte[7]),
        .MASK1 (m1_q),
        .MASK2 (m2_q),
        .o_0   (sub_byte[0]),
        .o_1   (sub_byte[1]),
        .o_2   (sub_byte[2]),
        .o_3   (sub_byte[3]),
        .o_4   (sub_byte[4]),
        .o_5   (sub_byte[5]),
        .o_6   (sub_byte[6]),
        .o_7   (sub_byte[7])
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        m1_d    = m1_q;
        m2_d    = m2_q;
        rnd_d   = rnd_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    data_d  = in_state;
                    m1_d    = in_m1;
                    m2_d    = in_m2;
                    rnd_d   = rnd;
                    cnt_d   = '0;
                    state_d = REFRESH_EN ? ST_REFRESH : ST_SUB;
                end
            end
            ST_REFRESH: begin
                data_d  = data_q ^ {NBYTES{refresh_pat}};
                m1_d    = rnd_q[0];
                m2_d    = rnd_q[1];
                cnt_d   = '0;
                state_d = ST_SUB;
            end
            ST_SUB: begin
                data_d[{cnt_q, 3'b000} +: 8] = sub_byte;
                if (cnt_q == LAST) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            m1_q    <= 1'b0;
            m2_q    <= 1'b0;
            rnd_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            m1_q    <= m1_d;
            m2_q    <= m2_d;
            rnd_q   <= rnd_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_REFRESH) || (state_q == ST_SUB);
    assign out_state = data_q;
    assign out_m1    = m1_q;
    assign out_m2    = m2_q;

endmodule
